// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 core: walks each instruction through the
// six stages with one-hot enables and owns the CC register, status code and retire counter.
module seq_stage_controller #(
  parameter int unsigned RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  input  logic [2:0]       cc_next,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic [2:0]       cc,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StPcUpd     = 3'd6,
    StHalted    = 3'd7
  } state_e;

  localparam logic [2:0] StatAok   = 3'd1;
  localparam logic [2:0] StatHlt   = 3'd2;
  localparam logic [2:0] StatAdr   = 3'd3;
  localparam logic [2:0] StatIns   = 3'd4;
  localparam logic [2:0] CcReset   = 3'b100;
  localparam logic [3:0] IcodeHalt = 4'h0;
  localparam logic [3:0] IcodeOpq  = 4'h6;
  localparam logic [3:0] IcodeMax  = 4'hB;

  state_e           state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic [2:0]       cc_q, cc_d;
  logic [2:0]       stat_q, stat_d;
  logic [RET_W-1:0] retired_q, retired_d;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    logic r;
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      icode_q   <= 4'h0;
      cc_q      <= CcReset;
      stat_q    <= StatAok;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      cc_q      <= cc_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    icode_d      = icode_q;
    cc_d         = cc_q;
    stat_d       = stat_q;
    retired_d    = retired_q;
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pc_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          stat_d  = StatAok;
        end
      end
      StFetch: begin
        fetch_en = 1'b1;
        icode_d  = icode;
        // Address error outranks everything, including a halt in the same cycle.
        if (imem_error) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end else if (!instr_valid || (icode > IcodeMax)) begin
          state_d = StHalted;
          stat_d  = StatIns;
        end else if (icode == IcodeHalt) begin
          state_d   = StHalted;
          stat_d    = StatHlt;
          retired_d = retired_q + RET_W'(1);
        end else begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        decode_en = 1'b1;
        state_d   = StExecute;
      end
      StExecute: begin
        execute_en = 1'b1;
        if (icode_q == IcodeOpq) begin
          cc_d = cc_next;
        end
        state_d = StMemory;
      end
      StMemory: begin
        if (is_mem_icode(icode_q)) begin
          memory_en = 1'b1;
          if (mem_ready) begin
            if (dmem_error) begin
              state_d = StHalted;
              stat_d  = StatAdr;
            end else begin
              state_d = StWriteback;
            end
          end
        end else begin
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        writeback_en = 1'b1;
        state_d      = StPcUpd;
      end
      StPcUpd: begin
        pc_en     = 1'b1;
        retired_d = retired_q + RET_W'(1);
        state_d   = StFetch;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy    = (state_q != StIdle) && (state_q != StHalted);
  assign cc      = cc_q;
  assign stat    = stat_q;
  assign retired = retired_q;

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencing controller for the sequential Y86-64 core. It steps one instruction at a time through Fetch, Decode, Execute, Memory, Writeback and PC-update by issuing one-hot stage enables. It owns the architectural condition-code register that feeds the Execute stage's CC input and captures its CC output. It also holds the processor status code and a retired-instruction counter.

## Interface
Parameters:
- RET_W, default 32, width of the retired-instruction counter.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution. Sampled only in IDLE.
- icode  in  4  instruction code from Fetch. Sampled at the edge leaving FETCH.
- instr_valid  in  1  Fetch reports a decodable instruction.
- imem_error  in  1  Fetch address error.
- mem_ready  in  1  data-memory access complete.
- dmem_error  in  1  data-memory address error. Qualified by mem_ready.
- cc_next  in  3  CC output from Execute, ordered {ZF,SF,OF}.
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables.
- cc  out  3  architectural CC {ZF,SF,OF}; drives Execute CC input.
- stat  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in every state except IDLE and HALTED.
- retired  out  RET_W  count of retired instructions.

## Operation
- States, 3-bit encoded: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- Stage enables are Moore outputs decoded from the state register. At most one enable is high in any cycle.
- IDLE:
  - start=1 → FETCH, and stat←AOK.
  - Otherwise remain in IDLE.
- FETCH: fetch_en=1. At the exit edge, icode_q←icode. Next state by priority:
  1. imem_error → HALTED, stat←ADR.
  2. !instr_valid or icode>4'hB → HALTED, stat←INS.
  3. icode==0 → HALTED, stat←HLT, retired+1.
  4. Otherwise → DECODE.
- DECODE: decode_en=1 → EXECUTE.
- EXECUTE: execute_en=1. If icode_q==6 (OPq), cc←cc_next at the exit edge; any other icode leaves cc unchanged. → MEMORY.
- MEMORY:
  - Memory icodes (4,5,8,9,A,B): memory_en=1. Stay in MEMORY until mem_ready=1.
    - mem_ready & dmem_error → HALTED, stat←ADR. No writeback, no PC update, no retire.
    - mem_ready & !dmem_error → WRITEBACK.
  - Other icodes: memory_en=0. Single cycle; mem_ready is ignored. → WRITEBACK.
- WRITEBACK: writeback_en=1 → PCUPD.
- PCUPD: pc_en=1, retired+1 at the exit edge → FETCH.
- HALTED: all enables 0, busy=0. start is ignored; only rst leaves this state.
- retired wraps modulo 2^RET_W.

## Timing
- Reset values (rst=1 at an edge): state=IDLE, all enables 0, busy=0, cc=3'b100, stat=1 (AOK), retired=0, icode_q=0.
- rst has priority over every other input in every state, including mid-MEMORY wait.
- start is sampled at edge N in IDLE → fetch_en is high during cycle N+1.
- Non-memory instruction: 6 cycles, FETCH through PCUPD. The next fetch_en follows PCUPD immediately.
- Memory instruction: 6+W cycles, where W is the number of MEMORY cycles sampled with mem_ready=0.
- A mem_ready already high on MEMORY entry gives W=0.
- cc changes only at the EXECUTE→MEMORY edge of an OPq. It is visible from the first MEMORY cycle.
- stat and retired update at the edge where the state transition occurs.
- Simultaneous imem_error and icode==0: ADR wins and retired is unchanged.

## Test plan
- Reset then start: after rst, check cc=100, stat=1, retired=0, enables 0. Pulse start=1 for one cycle → fetch_en=1 the next cycle, busy=1.
- OPq (icode=6), cc_next=3'b011: fetch, decode, execute, memory_en=0, writeback, pc enables each one cycle in order. cc=011 from cycle 4. retired=1. fetch_en again at cycle 7.
- rmmovq (icode=4), mem_ready low for 3 MEMORY cycles, cc_next=3'b111: memory_en high 4 cycles, instruction takes 9 cycles, cc stays 100, retired=1.
- halt (icode=0) after one OPq: HALTED, stat=2, retired=2, all enables 0. A later start pulse has no effect. rst → IDLE, stat=1.
- mrmovq (icode=5), mem_ready=1 with dmem_error=1: stat=3, no writeback_en/pc_en pulse, retired unchanged. Separately, imem_error=1 in FETCH → stat=3.
- Invalid icode=4'hC with instr_valid=1 → stat=4. Separately, rst asserted during a MEMORY wait → IDLE at the next edge, cc=100, retired=0.
